hires_mem_sched: RTL and testbench

HIRES_MEM_SCHED -- requirements
Module: hires_mem_sched

---
 rtl/hires_mem_sched.sv | 215 +++++++++++++++++++++
 tb/tb_hires_mem_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hires_mem_sched.sv
// Purpose: Z80 I/O-port front end for the hires RAM (X/Y address, data, options, optional bulk fill).
// Latency: OUT data -> RAM write in the next cycle; IN data -> rd_rdy three cycles after the strobe.
// Backpressure: none; strobes outside IDLE are dropped, and the fill engine stalls while the Z80 FSM is busy.
// Optional feature: define HIRES_FILL_EN to build the fill engine on port BASE_PORT+4.

module hires_mem_sched #(
    parameter logic [7:0] BASE_PORT = 8'h80
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        io_strobe,
    input  logic [7:0]  port_addr,
    input  logic        port_out,
    input  logic        port_in,
    input  logic [7:0]  din,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_oce,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  rd_data,
    output logic        rd_rdy,
    output logic [7:0]  options,
    output logic        busy
);

    localparam logic [7:0] PORT_X    = BASE_PORT;
    localparam logic [7:0] PORT_Y    = BASE_PORT + 8'd1;
    localparam logic [7:0] PORT_DATA = BASE_PORT + 8'd2;
    localparam logic [7:0] PORT_OPT  = BASE_PORT + 8'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_RD3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [6:0]  x;
    logic [7:0]  y;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_data_q;

    logic        acc;
    logic        wr_x;
    logic        wr_y;
    logic        wr_opt;
    logic        wr_cmd;
    logic        rd_cmd;
    logic        step_x;
    logic        step_y;

`ifdef HIRES_FILL_EN
    localparam logic [7:0] PORT_FILL = BASE_PORT + 8'd4;

    logic [6:0]  fx;
    logic [7:0]  fy;
    logic [7:0]  fill_byte;
    logic        fill_start;
    logic        fill_go;
`endif

    // Port decode: only strobes that land while the FSM is idle are honoured.
    always_comb begin
        acc    = io_strobe && (state == S_IDLE);
        wr_x   = acc && port_out && (port_addr == PORT_X);
        wr_y   = acc && port_out && (port_addr == PORT_Y);
        wr_opt = acc && port_out && (port_addr == PORT_OPT);
        wr_cmd = acc && port_out && (port_addr == PORT_DATA);
        rd_cmd = acc && port_in  && !port_out && (port_addr == PORT_DATA);
    end

    // Auto-step: writes step at the end of WR, reads at the end of RD2; step_n bits gate each axis.
    always_comb begin
        step_x = ((state == S_WR)  && !options[6]) ||
                 ((state == S_RD2) && !options[4]);
        step_y = ((state == S_WR)  && !options[7]) ||
                 ((state == S_RD2) && !options[5]);
    end

    // Address, options, write-data and read-result registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            x         <= 7'd0;
            y         <= 8'd0;
            options   <= 8'hFC;
            wr_byte   <= 8'd0;
            rd_data_q <= 8'd0;
        end else begin
            // x wraps naturally at 128; no clamp to the visible 80 columns
            if (wr_x) begin
                x <= din[6:0];
            end else if (step_x) begin
                x <= options[2] ? (x - 7'd1) : (x + 7'd1);
            end

            if (wr_y) begin
                y <= din;
            end else if (step_y) begin
                y <= options[3] ? (y - 8'd1) : (y + 8'd1);
            end

            if (wr_opt) begin
                options <= din;
            end

            if (wr_cmd) begin
                wr_byte <= din;
            end

            // hold the last read byte once RD3 has passed it through
            if (state == S_RD3) begin
                rd_data_q <= mem_dout;
            end
        end
    end

    // Z80 FSM state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Z80 FSM next state and RAM port A drive; fill cycles only use idle slots.
    always_comb begin
        state_nxt = state;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_oce   = 1'b0;
        mem_addr  = {x, y};
        mem_din   = wr_byte;
        rd_rdy    = 1'b0;
        rd_data   = rd_data_q;

        case (state)
            S_IDLE: begin
                if (wr_cmd) begin
                    state_nxt = S_WR;
                end else if (rd_cmd) begin
                    state_nxt = S_RD1;
                end
`ifdef HIRES_FILL_EN
                if (fill_go) begin
                    mem_ce   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {fx, fy};
                    mem_din  = fill_byte;
                end
`endif
            end
            S_WR: begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RD1: begin
                mem_ce    = 1'b1;
                state_nxt = S_RD2;
            end
            S_RD2: begin
                mem_oce   = 1'b1;
                state_nxt = S_RD3;
            end
            S_RD3: begin
                // RAM output register is valid now; present it alongside the pulse
                rd_rdy    = 1'b1;
                rd_data   = mem_dout;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef HIRES_FILL_EN
    always_comb begin
        fill_start = acc && port_out && (port_addr == PORT_FILL);
        fill_go    = busy && (state == S_IDLE);
    end

    // Fill engine: column-major sweep of fy 0..255 per fx, fx 0..79; holds while the Z80 owns the port.
    always_ff @(posedge clk) begin
        if (srst) begin
            busy      <= 1'b0;
            fx        <= 7'd0;
            fy        <= 8'd0;
            fill_byte <= 8'd0;
        end else if (fill_start) begin
            // a new start always wins, even mid-fill
            busy      <= 1'b1;
            fx        <= 7'd0;
            fy        <= 8'd0;
            fill_byte <= din;
        end else if (fill_go) begin
            if ((fx == 7'd79) && (fy == 8'hFF)) begin
                busy <= 1'b0;
            end else begin
                {fx, fy} <= {fx, fy} + 15'd1;
            end
        end
    end
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_hires_mem_sched.sv
// Purpose: scoreboard bench for hires_mem_sched with a behavioural dual-register RAM model.
// Latency: checks WR at T1, read pulse at T3, step results at T2/T3, fill length and ordering.
// Backpressure: exercises dropped strobes during WR and fill stalls under Z80 access.

module tb_hires_mem_sched;

    localparam logic [7:0] BASE = 8'h80;

    logic        clk = 1'b0;
    logic        srst;
    logic        io_strobe;
    logic [7:0]  port_addr;
    logic        port_out;
    logic        port_in;
    logic [7:0]  din;
    logic        mem_ce;
    logic        mem_we;
    logic        mem_oce;
    logic [14:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [7:0]  rd_data;
    logic        rd_rdy;
    logic [7:0]  options;
    logic        busy;

    always #5 clk = ~clk;

    hires_mem_sched #(.BASE_PORT(BASE)) dut (
        .clk       (clk),
        .srst      (srst),
        .io_strobe (io_strobe),
        .port_addr (port_addr),
        .port_out  (port_out),
        .port_in   (port_in),
        .din       (din),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_oce   (mem_oce),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .rd_data   (rd_data),
        .rd_rdy    (rd_rdy),
        .options   (options),
        .busy      (busy)
    );

    // RAM model: ce latches the read word, oce moves it to the output register
    logic [7:0] ram [0:32767];
    logic [7:0] ram_lat;
    logic [7:0] dout_q;

    always @(posedge clk) begin
        if (mem_ce && mem_we) ram[mem_addr] <= mem_din;
        if (mem_ce && !mem_we) ram_lat <= ram[mem_addr];
        if (mem_oce) dout_q <= ram_lat;
    end
    assign mem_dout = dout_q;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t        w;

    // reference model of the address registers
    logic [6:0] mx;
    logic [7:0] my;
    logic [7:0] mopt;

    logic       fill_mon = 1'b0;
    logic [7:0] fill_byte;
    int         fill_idx = 0;
    int         busy_cnt = 0;

    function automatic logic [7:0] stepv(input logic [7:0] v, input logic dec);
        return dec ? (v - 8'd1) : (v + 8'd1);
    endfunction

    // monitor: fill writes checked for sequence, Z80 writes and reads popped from the scoreboard
    always @(negedge clk) begin
        if (!srst) begin
            if (busy) busy_cnt++;
            if (mem_ce && mem_we) begin
                if (fill_mon && (mem_din == fill_byte)) begin
                    chk("fill_addr", {17'd0, mem_addr}, fill_idx);
                    fill_idx++;
                end else if (exp_wr.size() == 0) begin
                    chk("unexp_wr", exp_wr.size(), 1);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", {17'd0, mem_addr}, {17'd0, w.addr});
                    chk("wr_data", {24'd0, mem_din}, {24'd0, w.data});
                end
            end
            if (rd_rdy) begin
                if (exp_rd.size() == 0) chk("unexp_rd", exp_rd.size(), 1);
                else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
            end
        end
    end

    task automatic io(input logic [7:0] a, input logic is_out, input logic [7:0] d);
        @(posedge clk); #1;
        io_strobe = 1'b1; port_addr = a; port_out = is_out; port_in = !is_out; din = d;
        @(posedge clk); #1;
        io_strobe = 1'b0; port_out = 1'b0; port_in = 1'b0; din = 8'h00;
    endtask

    task automatic set_x(input logic [7:0] v);
        io(BASE, 1'b1, v); mx = v[6:0];
    endtask

    task automatic set_y(input logic [7:0] v);
        io(BASE + 8'd1, 1'b1, v); my = v;
    endtask

    task automatic set_opt(input logic [7:0] v);
        io(BASE + 8'd3, 1'b1, v); mopt = v;
        @(negedge clk); chk("opt_reg", {24'd0, options}, {24'd0, mopt});
    endtask

    task automatic z80_write(input logic [7:0] d, input logic chk_idle);
        wr_t        e;
        logic [7:0] t;
        e.addr = {mx, my}; e.data = d;
        exp_wr.push_back(e);
        io(BASE + 8'd2, 1'b1, d);
        @(negedge clk);
        chk("wr_t1_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 32'b110);
        t = stepv({1'b0, mx}, mopt[2]);
        if (!mopt[6]) mx = t[6:0];
        if (!mopt[7]) my = stepv(my, mopt[3]);
        if (chk_idle) begin
            @(negedge clk);
            chk("wr_t2_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 32'b000);
            chk("wr_t2_xy", {17'd0, mem_addr}, {17'd0, mx, my});
        end
    endtask

    task automatic z80_read(input logic [7:0] e);
        logic [7:0] t;
        exp_rd.push_back(e);
        io(BASE + 8'd2, 1'b0, 8'h00);
        @(negedge clk);
        chk("rd_t1_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 32'b100);
        @(negedge clk);
        chk("rd_t2_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 32'b001);
        chk("rd_t2_rdy", {31'd0, rd_rdy}, 0);
        t = stepv({1'b0, mx}, mopt[2]);
        if (!mopt[4]) mx = t[6:0];
        if (!mopt[5]) my = stepv(my, mopt[3]);
        @(negedge clk);
        chk("rd_t3_rdy", {31'd0, rd_rdy}, 1);
        chk("rd_t3_xy", {17'd0, mem_addr}, {17'd0, mx, my});
        @(negedge clk);
        chk("rd_t4_rdy", {31'd0, rd_rdy}, 0);
    endtask

    initial begin
        srst = 1'b1; io_strobe = 1'b0; port_addr = 8'h00;
        port_out = 1'b0; port_in = 1'b0; din = 8'h00;
        mx = 7'd0; my = 8'd0; mopt = 8'hFC;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_opt",  {24'd0, options}, 32'hFC);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd",   {23'd0, rd_data, rd_rdy}, 0);
        chk("rst_ctl",  {29'd0, mem_ce, mem_we, mem_oce}, 0);
        chk("rst_addr", {9'd0, mem_addr, mem_din}, 0);
        @(posedge clk); #1 srst = 1'b0;

        // write with increment, then with decrement on both axes
        set_opt(8'h30); set_x(8'd5); set_y(8'd10);
        z80_write(8'hAA, 1'b1);
        set_opt(8'h3C);
        z80_write(8'h11, 1'b1);

        // reads: increment then decrement read-step
        set_opt(8'hFC); set_x(8'd6); set_y(8'd11);
        z80_write(8'h5A, 1'b1);
        set_opt(8'hC0);
        z80_read(8'h5A);
        set_x(8'd5); set_y(8'd10); set_opt(8'hCC);
        z80_read(8'hAA);

        // wrap-around on both axes, and x-only stepping
        set_opt(8'h30); set_x(8'h10); set_y(8'hFF);
        z80_write(8'h01, 1'b1);
        set_opt(8'h3C); set_x(8'h00); set_y(8'h20);
        z80_write(8'h02, 1'b1);
        set_opt(8'h30); set_y(8'h40);
        z80_write(8'h03, 1'b1);
        set_opt(8'hB0);
        z80_write(8'h04, 1'b1);

        // a strobe landing during WR is dropped
        set_opt(8'h30); set_x(8'h20); set_y(8'h30);
        begin
            wr_t e;
            e.addr = {mx, my}; e.data = 8'h77;
            exp_wr.push_back(e);
        end
        io(BASE + 8'd2, 1'b1, 8'h77);
        io_strobe = 1'b1; port_addr = BASE; port_out = 1'b1; din = 8'h55;
        @(posedge clk); #1;
        io_strobe = 1'b0; port_out = 1'b0; din = 8'h00;
        mx = mx + 7'd1; my = my + 8'd1;
        @(negedge clk);
        chk("drop_xy", {17'd0, mem_addr}, {17'd0, mx, my});

        // undecoded ports change nothing
        io(BASE + 8'd5, 1'b1, 8'h12);
        io(8'h00, 1'b1, 8'h13);
        @(negedge clk);
        chk("undec_xy",  {17'd0, mem_addr}, {17'd0, mx, my});
        chk("undec_opt", {24'd0, options}, {24'd0, mopt});
        chk("undec_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 0);

`ifdef HIRES_FILL_EN
        begin
            int cyc;
            logic [14:0] a;
            // uninterrupted fill
            fill_mon = 1'b1; fill_byte = 8'hFF; fill_idx = 0; busy_cnt = 0;
            io(BASE + 8'd4, 1'b1, 8'hFF);
            @(negedge clk);
            chk("fill_busy_t1", {31'd0, busy}, 1);
            cyc = 0;
            while (busy && cyc < 25000) begin @(negedge clk); cyc++; end
            chk("fill_done", {31'd0, busy}, 0);
            chk("fill_writes", fill_idx, 20480);
            chk("fill_busy_cnt", busy_cnt, 20480);
            a = 15'h4FFF;
            chk("fill_last", {24'd0, ram[a]}, 32'hFF);

            // fill with one Z80 write in the middle
            set_opt(8'hFC); set_x(8'd100); set_y(8'd7);
            fill_byte = 8'hA5; fill_idx = 0; busy_cnt = 0;
            io(BASE + 8'd4, 1'b1, 8'hA5);
            repeat (50) @(posedge clk);
            z80_write(8'h33, 1'b0);
            cyc = 0;
            while (busy && cyc < 25000) begin @(negedge clk); cyc++; end
            chk("fill2_done", {31'd0, busy}, 0);
            chk("fill2_writes", fill_idx, 20480);
            chk("fill2_busy_cnt", busy_cnt, 20481);
            a = {7'd100, 8'd7};
            chk("fill2_z80_byte", {24'd0, ram[a]}, 32'h33);

            // reset aborts a fill
            fill_byte = 8'h77; fill_idx = 0;
            io(BASE + 8'd4, 1'b1, 8'h77);
            repeat (10) @(posedge clk);
            #1 srst = 1'b1;
            @(posedge clk); #1 srst = 1'b0;
            mx = 7'd0; my = 8'd0; mopt = 8'hFC;
            repeat (3) begin
                @(negedge clk);
                chk("fill_abort_busy", {31'd0, busy}, 0);
                chk("fill_abort_ce", {31'd0, mem_ce}, 0);
            end
            chk("fill_abort_cnt", fill_idx, 10);
            fill_mon = 1'b0;
        end
`else
        io(BASE + 8'd4, 1'b1, 8'hFF);
        repeat (4) begin
            @(negedge clk);
            chk("nofill_busy", {31'd0, busy}, 0);
            chk("nofill_ctl", {29'd0, mem_ce, mem_we, mem_oce}, 0);
        end
`endif

        // reset during RD2 aborts the read and clears state
        set_opt(8'hC0); set_x(8'd3); set_y(8'd4);
        io(BASE + 8'd2, 1'b0, 8'h00);
        @(posedge clk); #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        mx = 7'd0; my = 8'd0; mopt = 8'hFC;
        repeat (3) begin
            @(negedge clk);
            chk("srst_rdy", {31'd0, rd_rdy}, 0);
        end
        chk("srst_xy",  {17'd0, mem_addr}, 0);
        chk("srst_opt", {24'd0, options}, 32'hFC);

        // reset wins over a coincident strobe
        @(posedge clk); #1;
        srst = 1'b1; io_strobe = 1'b1; port_addr = BASE; port_out = 1'b1; din = 8'h09;
        @(posedge clk); #1;
        srst = 1'b0; io_strobe = 1'b0; port_out = 1'b0; din = 8'h00;
        @(negedge clk);
        chk("srst_strobe_xy", {17'd0, mem_addr}, 0);

        repeat (3) @(negedge clk);
        chk("wr_q_empty", exp_wr.size(), 0);
        chk("rd_q_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
